// File: rtl/dmem_bus_bridge_pkg.sv
// dmem_bus_bridge_pkg: shared FSM encoding and error-data default for the
// data-memory bus bridge, its hazard-unit bench and the core top level.
package dmem_bus_bridge_pkg;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
   localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/dmem_bus_bridge_if.sv
// dmem_bus_bridge_if: memory-stage pipeline side plus external data bus,
// seen from the bridge (master) and from the memory/pipeline side (slave).
interface dmem_bus_bridge_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
);
   logic                     mem_read;
   logic                     mem_write;
   logic [ADDRESS_WIDTH-1:0] alu_out;
   logic [DATA_WIDTH-1:0]    write_data;
   logic [DATA_WIDTH-1:0]    read_data;
   logic                     stall;
   logic                     bus_err;
   logic                     bus_req;
   logic                     bus_we;
   logic [ADDRESS_WIDTH-1:0] bus_addr;
   logic [DATA_WIDTH-1:0]    bus_wdata;
   logic                     bus_ack;
   logic [DATA_WIDTH-1:0]    bus_rdata;
   modport master (
      input  mem_read, mem_write, alu_out, write_data, bus_ack, bus_rdata,
      output read_data, stall, bus_err, bus_req, bus_we, bus_addr, bus_wdata
   );
   modport slave (
      output mem_read, mem_write, alu_out, write_data, bus_ack, bus_rdata,
      input  read_data, stall, bus_err, bus_req, bus_we, bus_addr, bus_wdata
   );
endinterface

// File: rtl/dmem_bus_bridge_bus_timeout_counter.sv
// bus_timeout_counter: counts request cycles; terminal is high on the last
// request cycle allowed before the bridge aborts the access.
module bus_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic terminal
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0] count;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else count <= clear ? '0 : enable ? count + 1'b1 : count;
   assign terminal = count == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns an M-stage load/store into a registered req/ack bus
// transaction, stalling the pipeline until it completes or times out.
module dmem_bus_bridge
   import dmem_bus_bridge_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_WIDTH  = 32,
   parameter int TIMEOUT_CYCLES = 255,
   parameter logic [DATA_WIDTH-1:0] ERR_RDATA = DATA_WIDTH'(ERR_RDATA_DEFAULT)
) (
   input logic              i_CLK,
   input logic              i_RST,
   dmem_bus_bridge_if.master bus
);
   state_t                   state, next;
   logic                     access, aligned, go, bad, timeout, ack_req, abort;
   logic                     req, we, err;
   logic [ADDRESS_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0]    wdata, rdata;
   assign access  = bus.mem_read | bus.mem_write;
   assign aligned = bus.alu_out[1:0] == 2'b00;
   assign go      = state == S_IDLE && access && aligned;
   assign bad     = state == S_IDLE && access && !aligned;
   assign ack_req = state == S_REQ && bus.bus_ack;
   // an ack in the terminal cycle still completes the access cleanly
   assign abort   = state == S_REQ && !bus.bus_ack && timeout;
   bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk(i_CLK), .rst_n(i_RST), .clear(go), .enable(state == S_REQ), .terminal(timeout)
   );
   always_comb begin
      next = state;
      next = state == S_IDLE ? (go ? S_REQ : S_IDLE)
           : state == S_REQ  ? ((ack_req || abort) ? S_DONE : S_REQ)
           : S_IDLE;
   end
   always_ff @(posedge i_CLK or negedge i_RST)
      if (!i_RST) begin
         state <= S_IDLE;
         req   <= 1'b0;
         we    <= 1'b0;
         addr  <= '0;
         wdata <= '0;
         rdata <= '0;
         err   <= 1'b0;
      end else begin
         state <= next;
         req   <= next == S_REQ;
         if (go) begin
            addr  <= {bus.alu_out[ADDRESS_WIDTH-1:2], 2'b00};
            we    <= bus.mem_write;
            wdata <= bus.write_data;
         end
         if (ack_req && !we) rdata <= bus.bus_rdata;
         else if (abort) rdata <= ERR_RDATA;
         if (bad || abort) err <= 1'b1;
      end
   assign bus.stall     = go || state == S_REQ;
   assign bus.read_data = bad ? ERR_RDATA : rdata;
   assign bus.bus_err   = err;
   assign bus.bus_req   = req;
   assign bus.bus_we    = we;
   assign bus.bus_addr  = addr;
   assign bus.bus_wdata = wdata;
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: directed vectors with hand-computed expectations,
// bridge built with a 4-cycle timeout so abort and ack/timeout ties are reachable.
module tb_dmem_bus_bridge;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   always #5 clk = ~clk;
   dmem_bus_bridge_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bif ();
   dmem_bus_bridge #(
      .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(4), .ERR_RDATA(32'h0)
   ) dut (
      .i_CLK(clk), .i_RST(rst), .bus(bif)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_inputs();
      bif.mem_read  = 1'b0;
      bif.mem_write = 1'b0;
      bif.bus_ack   = 1'b0;
   endtask
   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
   endtask
   initial begin
      idle_inputs();
      bif.alu_out    = '0;
      bif.write_data = '0;
      bif.bus_rdata  = '0;
      #12;
      check("rst_req", bif.bus_req, 0);
      check("rst_we", bif.bus_we, 0);
      check("rst_addr", bif.bus_addr, 0);
      check("rst_wdata", bif.bus_wdata, 0);
      check("rst_rdata", bif.read_data, 0);
      check("rst_err", bif.bus_err, 0);
      check("rst_stall", bif.stall, 0);
      tick();
      rst = 1'b1;
      tick();
      // load, ack on first REQ cycle
      bif.mem_read = 1'b1;
      bif.alu_out  = 32'h0000_0010;
      #1;
      check("ld_n_stall", bif.stall, 1);
      check("ld_n_req", bif.bus_req, 0);
      tick();
      check("ld_req", bif.bus_req, 1);
      check("ld_stall", bif.stall, 1);
      check("ld_addr", bif.bus_addr, 32'h10);
      check("ld_we", bif.bus_we, 0);
      bif.bus_ack   = 1'b1;
      bif.bus_rdata = 32'h1234_5678;
      tick();
      bif.bus_ack = 1'b0;
      check("ld_done_req", bif.bus_req, 0);
      check("ld_done_stall", bif.stall, 0);
      check("ld_done_data", bif.read_data, 32'h1234_5678);
      check("ld_done_err", bif.bus_err, 0);
      bif.mem_read = 1'b0;
      tick();
      check("ld_idle_stall", bif.stall, 0);
      // store, ack in 4th REQ cycle (coincides with terminal count)
      bif.mem_write  = 1'b1;
      bif.alu_out    = 32'h0000_0100;
      bif.write_data = 32'hCAFE_F00D;
      #1;
      check("st_n_stall", bif.stall, 1);
      tick();
      bif.alu_out    = 32'hFFFF_FFF0;
      bif.write_data = 32'h0;
      bif.bus_rdata  = 32'hDEAD_BEEF;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("st_req%0d", i), bif.bus_req, 1);
         check($sformatf("st_stall%0d", i), bif.stall, 1);
         check($sformatf("st_we%0d", i), bif.bus_we, 1);
         check($sformatf("st_addr%0d", i), bif.bus_addr, 32'h100);
         check($sformatf("st_wdata%0d", i), bif.bus_wdata, 32'hCAFE_F00D);
         if (i == 3) bif.bus_ack = 1'b1;
         tick();
      end
      bif.bus_ack = 1'b0;
      check("st_done_req", bif.bus_req, 0);
      check("st_done_stall", bif.stall, 0);
      check("st_done_err", bif.bus_err, 0);
      check("st_done_data", bif.read_data, 32'h1234_5678);
      bif.mem_write = 1'b0;
      tick();
      // load that never gets acked
      bif.mem_read = 1'b1;
      bif.alu_out  = 32'h0000_0020;
      tick();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("to_req%0d", i), bif.bus_req, 1);
         check($sformatf("to_stall%0d", i), bif.stall, 1);
         tick();
      end
      check("to_done_req", bif.bus_req, 0);
      check("to_done_stall", bif.stall, 0);
      check("to_done_data", bif.read_data, 32'h0);
      check("to_done_err", bif.bus_err, 1);
      bif.mem_read  = 1'b0;
      bif.bus_ack   = 1'b1;
      bif.bus_rdata = 32'h7777_7777;
      tick();
      check("late_ack_req", bif.bus_req, 0);
      check("late_ack_stall", bif.stall, 0);
      tick();
      check("late_ack_req2", bif.bus_req, 0);
      check("late_ack_data", bif.read_data, 32'h0);
      check("late_ack_err", bif.bus_err, 1);
      bif.bus_ack = 1'b0;
      do_reset();
      check("rst2_err", bif.bus_err, 0);
      // back-to-back store then load
      bif.mem_write  = 1'b1;
      bif.alu_out    = 32'h0000_0200;
      bif.write_data = 32'h1111_2222;
      tick();
      check("bb_st_req", bif.bus_req, 1);
      bif.bus_ack = 1'b1;
      tick();
      bif.bus_ack = 1'b0;
      check("bb_st_done_req", bif.bus_req, 0);
      check("bb_st_done_stall", bif.stall, 0);
      bif.mem_write = 1'b0;
      bif.mem_read  = 1'b1;
      bif.alu_out   = 32'h0000_0204;
      tick();
      check("bb_gap_req", bif.bus_req, 0);
      check("bb_gap_stall", bif.stall, 1);
      tick();
      check("bb_ld_req", bif.bus_req, 1);
      check("bb_ld_addr", bif.bus_addr, 32'h204);
      check("bb_ld_we", bif.bus_we, 0);
      bif.bus_ack   = 1'b1;
      bif.bus_rdata = 32'h55AA_55AA;
      tick();
      bif.bus_ack = 1'b0;
      check("bb_ld_done_req", bif.bus_req, 0);
      check("bb_ld_done_data", bif.read_data, 32'h55AA_55AA);
      bif.mem_read = 1'b0;
      tick();
      // misaligned load
      bif.mem_read = 1'b1;
      bif.alu_out  = 32'h0000_0102;
      #1;
      check("mis_req", bif.bus_req, 0);
      check("mis_stall", bif.stall, 0);
      check("mis_data", bif.read_data, 32'h0);
      check("mis_err_pre", bif.bus_err, 0);
      tick();
      bif.mem_read = 1'b0;
      check("mis_err", bif.bus_err, 1);
      check("mis_req2", bif.bus_req, 0);
      check("mis_stall2", bif.stall, 0);
      tick();
      check("mis_err_sticky", bif.bus_err, 1);
      // reset during second REQ cycle
      bif.mem_read = 1'b1;
      bif.alu_out  = 32'h0000_0300;
      tick();
      tick();
      check("mr_req", bif.bus_req, 1);
      bif.mem_read = 1'b0;
      rst = 1'b0;
      #1;
      check("mr_req_drop", bif.bus_req, 0);
      check("mr_stall", bif.stall, 0);
      check("mr_err", bif.bus_err, 0);
      check("mr_addr", bif.bus_addr, 0);
      check("mr_we", bif.bus_we, 0);
      check("mr_data", bif.read_data, 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      bif.bus_ack   = 1'b1;
      bif.bus_rdata = 32'h9999_9999;
      tick();
      check("mr_ack_req", bif.bus_req, 0);
      check("mr_ack_data", bif.read_data, 0);
      bif.bus_ack = 1'b0;
      tick();
      check("mr_after_data", bif.read_data, 0);
      check("mr_after_stall", bif.stall, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/dmem_bus_bridge.md
# dmem_bus_bridge

Data-memory bus bridge for the pipelined MIPS core; sits directly downstream of the execute-to-memory pipeline register and replaces the single-cycle data memory inside the memory stage. It turns a load or store in M into a registered request/acknowledge transaction on an external data bus. While the transaction is outstanding it freezes the whole pipeline through a stall output to the hazard unit. It returns load data to the memory-to-writeback register and flags misaligned or timed-out accesses.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDRESS_WIDTH, 32, byte address width
- TIMEOUT_CYCLES, 255, maximum REQ cycles without acknowledge before abort; legal range 2..65535
- ERR_RDATA, 32'h0000_0000, load data returned on an aborted or misaligned access

- i_CLK  in  1  core clock; only clock
- i_RST  in  1  asynchronous, active-low reset
- i_MemReadM  in  1  load in M stage
- i_MemWriteM  in  1  store in M stage
- i_ALUOutM  in  ADDRESS_WIDTH  byte address
- i_WriteDataM  in  DATA_WIDTH  store data
- o_ReadDataM  out  DATA_WIDTH  load data to the memory-to-writeback register
- o_StallM  out  1  freeze all pipeline registers and PC
- o_BusErr  out  1  sticky error flag
- o_BusReq  out  1  bus request
- o_BusWe  out  1  1 = write
- o_BusAddr  out  ADDRESS_WIDTH  word-aligned address: {i_ALUOutM[ADDRESS_WIDTH-1:2], 2'b00}
- o_BusWData  out  DATA_WIDTH  write data
- i_BusAck  in  1  one-cycle completion strobe
- i_BusRData  in  DATA_WIDTH  read data, valid when i_BusAck = 1

## Operation
- FSM with three states.
- IDLE
  - Access = i_MemReadM | i_MemWriteM.
  - If access is present and aligned (i_ALUOutM[1:0] == 0): latch address, write data and write-enable (i_MemWriteM wins if both are set); go to REQ. o_StallM = 1 combinationally in this cycle.
  - If access is present and misaligned: no bus transaction and no stall; o_ReadDataM = ERR_RDATA; set o_BusErr; stay in IDLE.
- REQ
  - o_BusReq = 1 (registered); bus address, write-enable and write data are held stable from the latches; o_StallM = 1.
  - Timeout counter increments each cycle.
  - i_BusAck = 1: capture i_BusRData (reads only), go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 with no ack: capture ERR_RDATA, set o_BusErr, go to DONE.
  - Ack and timeout in the same cycle: ack wins, no error.
- DONE
  - o_BusReq = 0, o_StallM = 0, o_ReadDataM = captured data.
  - Pipeline advances at this edge; unconditional return to IDLE.
  - A back-to-back access in M is therefore seen in the following IDLE cycle.
- i_BusAck outside REQ is ignored.
- o_BusErr stays set until reset.
- o_ReadDataM in IDLE with no access = captured register (don't-care to the pipeline).

## Timing
- Reset values: state IDLE; o_BusReq 0, o_BusWe 0, o_BusAddr 0, o_BusWData 0, o_ReadDataM 0, o_BusErr 0, counter 0. o_StallM 0 when inputs are idle.
- Load or store entering M at cycle N, ack sampled at cycle N+k (k ≥ 1):
  - req is high during N+1..N+k;
  - stall is high during N..N+k;
  - DONE is at N+k+1.
- Minimum M-stage occupancy is 3 cycles (2 stall cycles).
- Timeout abort occurs after TIMEOUT_CYCLES request cycles; stall spans TIMEOUT_CYCLES+1 cycles.
- Reset mid-transaction: o_BusReq drops asynchronously and state returns to IDLE; an ack arriving after reset release is ignored.
- Inputs from M are assumed stable while o_StallM = 1; the bridge relies only on its latched copies.

## Structure
- Shared package: FSM state encoding (IDLE/REQ/DONE) and the ERR_RDATA default constant, for use by the hazard unit bench and the top level.
- One sub-module, bus_timeout_counter:
  - clear on entry to REQ, enable in REQ, terminal-count output;
  - width = $clog2(TIMEOUT_CYCLES).
- Top-level integration:
  - o_StallM ORs into StallF/StallD;
  - it also gates the enables of the E/M and M/W registers and blocks FlushE.

## Test plan
- Load from 0x0000_0010, ack on the first REQ cycle with 0x1234_5678 -> req high 1 cycle, stall high 2 cycles, o_ReadDataM = 0x1234_5678 in DONE, o_BusErr = 0.
- Store 0xCAFE_F00D to 0x0000_0100, ack after 4 REQ cycles -> o_BusWe = 1, o_BusWData/o_BusAddr stable for all 4 cycles, stall high 5 cycles.
- Load to 0x0000_0102 (misaligned) -> no o_BusReq, no stall, o_ReadDataM = 0, o_BusErr rises next edge and stays set.
- TIMEOUT_CYCLES = 4, never ack -> req high exactly 4 cycles, DONE returns 0, o_BusErr = 1; a late ack in IDLE is ignored.
- Back-to-back store then load, each acked after 1 cycle -> second request begins the cycle after DONE, no overlap of o_BusReq pulses.
- i_RST low during REQ cycle 2 -> o_BusReq = 0 immediately; all outputs at reset values; a subsequent ack produces no DONE.
